zynq_axil_stream_bridge: RTL

- AXI4-Lite slave that turns host (PS) register traffic on a 32-bit control port into two buffered valid/ready word streams.
- Sits directly downstream of the top-level s02 AXI-Lite slave port, in the PL fabric.
  - Host writes push words into an outbound FIFO that feeds the accelerator/core.
  - Host reads pop words from an inbound FIFO that the accelerator/core fills.
- Occupancy registers let host software poll instead of blocking.

---
 rtl/zynq_axil_stream_bridge.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/zynq_axil_stream_bridge.sv
// -----------------------------------------------------------------------------
// zynq_axil_stream_bridge
//
// AXI4-Lite slave that turns host register traffic into two buffered word
// streams. Host writes to OUT_DATA push into an outbound FIFO feeding the core;
// host reads of IN_DATA pop from an inbound FIFO filled by the core. Occupancy
// registers let software poll instead of blocking on a stalled response.
//
// Register map (addr[3:2]):
//   0 OUT_DATA  (W)  push word; SLVERR and drop when the outbound FIFO is full
//   1 IN_DATA   (R)  pop word;  SLVERR and rdata=0 when the inbound FIFO is empty
//   2 OUT_FREE  (R)  out_els_p - outbound occupancy
//   3 IN_COUNT  (R)  inbound occupancy
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*         AXI-Lite write channels (wstrb ignored)
//   s_axil_ar*/r*            AXI-Lite read channels
//   out_data_o/out_v_o/out_ready_i   outbound stream (FIFO head)
//   in_data_i/in_v_i/in_ready_o      inbound stream
// -----------------------------------------------------------------------------
module zynq_axil_stream_bridge #(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32,
    parameter int out_els_p    = 8,
    parameter int in_els_p     = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [addr_width_p-1:0] s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [data_width_p-1:0] s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [addr_width_p-1:0] s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [data_width_p-1:0] s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [data_width_p-1:0] out_data_o,
    output logic                    out_v_o,
    input  logic                    out_ready_i,
    input  logic [data_width_p-1:0] in_data_i,
    input  logic                    in_v_i,
    output logic                    in_ready_o
);

    localparam int out_ptr_w_lp = $clog2(out_els_p);
    localparam int out_cnt_w_lp = $clog2(out_els_p + 1);
    localparam int in_ptr_w_lp  = $clog2(in_els_p);
    localparam int in_cnt_w_lp  = $clog2(in_els_p + 1);

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    localparam logic [1:0] REG_OUT_DATA = 2'd0;
    localparam logic [1:0] REG_IN_DATA  = 2'd1;
    localparam logic [1:0] REG_OUT_FREE = 2'd2;
    localparam logic [1:0] REG_IN_COUNT = 2'd3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

    // Held low through reset so every ready output reads 0 while aresetn is low.
    logic                    r_live;

    logic                    r_wr_state;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [1:0]              r_aw_reg;
    logic [data_width_p-1:0] r_wdata;
    logic [1:0]              r_bresp;

    logic                    r_rd_state;
    logic [data_width_p-1:0] r_rdata;
    logic [1:0]              r_rresp;

    logic [data_width_p-1:0] r_out_mem [out_els_p];
    logic [out_ptr_w_lp-1:0] r_out_wptr;
    logic [out_ptr_w_lp-1:0] r_out_rptr;
    logic [out_cnt_w_lp-1:0] r_out_count;

    logic [data_width_p-1:0] r_in_mem [in_els_p];
    logic [in_ptr_w_lp-1:0]  r_in_wptr;
    logic [in_ptr_w_lp-1:0]  r_in_rptr;
    logic [in_cnt_w_lp-1:0]  r_in_count;
    logic                    r_in_ready;

    logic                    w_aw_hs, w_w_hs, w_ar_hs;
    logic                    w_wr_fire;
    logic [1:0]              w_wr_reg;
    logic [data_width_p-1:0] w_wr_data;
    logic                    w_out_full, w_out_push, w_out_pop;
    logic                    w_in_empty, w_in_push, w_in_pop;
    logic [out_cnt_w_lp-1:0] w_out_count_nxt;
    logic [in_cnt_w_lp-1:0]  w_in_count_nxt;
    logic [1:0]              w_rd_reg;
    logic [data_width_p-1:0] w_rd_data;
    logic [1:0]              w_rd_resp;
    logic                    w_unused;

    // Strobes and undecoded address bits have no effect.
    assign w_unused = ^{s_axil_wstrb, s_axil_awaddr, s_axil_araddr};

    // ---------------- write path ----------------
    assign s_axil_awready = r_live & (r_wr_state == ST_IDLE) & ~r_aw_held;
    assign s_axil_wready  = r_live & (r_wr_state == ST_IDLE) & ~r_w_held;
    assign s_axil_bvalid  = (r_wr_state == ST_RESP);
    assign s_axil_bresp   = r_bresp;

    assign w_aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_w_hs  = s_axil_wvalid  & s_axil_wready;

    // A handshake completing this cycle counts as held, so the action fires on
    // the later of the two handshakes and bvalid follows one cycle later.
    assign w_wr_fire = (r_wr_state == ST_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_reg  = r_aw_held ? r_aw_reg : s_axil_awaddr[3:2];
    assign w_wr_data = r_w_held  ? r_wdata  : s_axil_wdata;

    // Fullness is taken from the registered count: a same-cycle pop does not
    // make room for this write.
    assign w_out_full = (r_out_count == out_cnt_w_lp'(out_els_p));
    assign w_out_push = w_wr_fire & (w_wr_reg == REG_OUT_DATA) & ~w_out_full;
    assign w_out_pop  = out_v_o & out_ready_i;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every always_ff block sees the pre-edge value of every register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_live     <= 1'b0;
            r_wr_state <= ST_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_reg   <= '0;
            r_wdata    <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_reg  <= s_axil_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil_wdata;
            end
            if (w_wr_fire) begin
                r_wr_state <= ST_RESP;
                r_bresp    <= ((w_wr_reg == REG_OUT_DATA) && w_out_full) ? RESP_SLVERR : RESP_OKAY;
            end else if ((r_wr_state == ST_RESP) && s_axil_bready) begin
                r_wr_state <= ST_IDLE;
                r_aw_held  <= 1'b0;
                r_w_held   <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    assign s_axil_arready = r_live & (r_rd_state == ST_IDLE);
    assign s_axil_rvalid  = (r_rd_state == ST_RESP);
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;

    assign w_ar_hs    = s_axil_arvalid & s_axil_arready;
    assign w_rd_reg   = s_axil_araddr[3:2];
    assign w_in_empty = (r_in_count == '0);
    assign w_in_pop   = w_ar_hs & (w_rd_reg == REG_IN_DATA) & ~w_in_empty;

    // Counts come from the registers, i.e. before this cycle's push/pop.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_reg)
            REG_IN_DATA: begin
                if (w_in_empty) w_rd_resp = RESP_SLVERR;
                else            w_rd_data = r_in_mem[r_in_rptr];
            end
            REG_OUT_FREE: w_rd_data = data_width_p'(out_els_p) - data_width_p'(r_out_count);
            REG_IN_COUNT: w_rd_data = data_width_p'(r_in_count);
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= ST_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rd_state <= ST_RESP;
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
        end else if ((r_rd_state == ST_RESP) && s_axil_rready) begin
            r_rd_state <= ST_IDLE;
        end
    end

    // ---------------- outbound FIFO ----------------
    assign out_v_o    = (r_out_count != '0);
    assign out_data_o = r_out_mem[r_out_rptr];
    assign w_out_count_nxt = r_out_count + out_cnt_w_lp'(w_out_push) - out_cnt_w_lp'(w_out_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_wptr  <= '0;
            r_out_rptr  <= '0;
            r_out_count <= '0;
        end else begin
            if (w_out_push) r_out_wptr <= r_out_wptr + 1'b1;
            if (w_out_pop)  r_out_rptr <= r_out_rptr + 1'b1;
            r_out_count <= w_out_count_nxt;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts define which
    // entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge aclk) begin
        if (w_out_push) r_out_mem[r_out_wptr] <= w_wr_data;
    end

    // ---------------- inbound FIFO ----------------
    assign in_ready_o = r_in_ready;
    assign w_in_push  = in_v_i & r_in_ready;
    assign w_in_count_nxt = r_in_count + in_cnt_w_lp'(w_in_push) - in_cnt_w_lp'(w_in_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_count <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_in_push) r_in_wptr <= r_in_wptr + 1'b1;
            if (w_in_pop)  r_in_rptr <= r_in_rptr + 1'b1;
            r_in_count <= w_in_count_nxt;
            // Registered from the next occupancy so it never allows an overflow.
            r_in_ready <= (w_in_count_nxt != in_cnt_w_lp'(in_els_p));
        end
    end

    always_ff @(posedge aclk) begin
        if (w_in_push) r_in_mem[r_in_wptr] <= in_data_i;
    end

endmodule
